sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//  Single-clock, parametrised FIFO; successor to the fixed 8x16 buffer block.
//  Generalised in WIDTH/DEPTH, uses all DEPTH entries, first-word-fall-through read side.
//  Adds occupancy count, programmable almost-full/almost-empty flags and optional sticky error flags.
//  Sits between a producer and a consumer in the same clock domain.
// PARAMETERS
//  WIDTH     16  data word width in bits (>=1)
//  DEPTH     8   number of entries; power of two, >=2
//  AF_LEVEL  6   almost_full asserted when fill_count >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL  1   almost_empty asserted when fill_count <= AE_LEVEL (0..DEPTH-1)
// PORTS
//  clock         in   1                  single clock, rising edge
//  reset         in   1                  asynchronous, active-low (0 = reset)
//  wr_en         in   1                  write request
//  wr_data       in   WIDTH              write data
//  rd_en         in   1                  read (pop) request
//  rd_data       out  WIDTH              head-of-queue data (FWFT)
//  rd_valid      out  1                  rd_data valid (= ~buffer_empty)
//  buffer_empty  out  1                  fill_count == 0
//  buffer_full   out  1                  fill_count == DEPTH
//  almost_empty  out  1                  fill_count <= AE_LEVEL
//  almost_full   out  1                  fill_count >= AF_LEVEL
//  fill_count    out  $clog2(DEPTH)+1    registered occupancy, 0..DEPTH
//  err_clr       in   1                  clears sticky error flags (macro only)
//  overflow      out  1                  sticky: write rejected
//  underflow     out  1                  sticky: read on empty
// BEHAVIOUR
//  - Reset (reset=0, async): pointers=0, fill_count=0, overflow=underflow=0;
//    buffer_empty=1, rd_valid=0, almost_empty=1, buffer_full=0, almost_full=0 (AF_LEVEL>=1).
//    Memory contents not reset. Reset mid-operation discards all data immediately.
//  - Pointers: wr_ptr/rd_ptr are $clog2(DEPTH)+1 bits; low bits index memory, wrap naturally.
//  - push = wr_en & (~buffer_full | pop); pop = rd_en & ~buffer_empty.
//  - Write: on push, mem[wr_ptr] <= wr_data, wr_ptr++ at rising edge.
//  - Read (FWFT): rd_data = mem[rd_ptr] combinationally while rd_valid=1; on pop, rd_ptr++.
//    rd_data is don't-care while rd_valid=0.
//  - Latency: word written at edge N is visible on rd_data/rd_valid after edge N (0-cycle read).
//  - fill_count: +1 on push only, -1 on pop only, unchanged on both or neither.
//  - Full + wr_en + rd_en: pop and push both occur; count stays DEPTH; no overflow.
//  - Full + wr_en, no rd_en: write dropped, memory/pointers unchanged.
//  - Empty + rd_en (+ wr_en): no pop; write still accepted; no bypass to rd_data same cycle.
//  - All flags derived combinationally from registered fill_count; no glitch on unchanged count.
// CONFIGURATION
//  Macro SYNC_FIFO_STICKY_ERR_EN:
//  - Defined: overflow set at edge where wr_en & buffer_full & ~pop;
//    underflow set at edge where rd_en & buffer_empty. Both held until err_clr=1
//    (clears at next edge; a new error in the same cycle as err_clr wins -> flag stays 1)
//    or reset.
//  - Undefined: overflow=underflow=0 constant, err_clr ignored; ports remain present.
//  FIFO data behaviour identical in both builds.
// TESTING
//  1 Reset: drive reset=0 mid-traffic -> fill_count=0, buffer_empty=1, rd_valid=0 at once, no clock.
//  2 Fill/drain, defaults: write 0x0001..0x0008 -> buffer_full=1, fill_count=8, almost_full from count 6;
//    read 8 -> data in order 0x0001..0x0008, buffer_empty=1.
//  3 Wrap: 20 push/pop cycles, varied occupancy -> data order preserved across pointer wrap, count matches model.
//  4 Full + simultaneous wr_en/rd_en with 0xBEEF -> head popped, 0xBEEF enqueued, count stays 8, overflow=0.
//  5 Error flags (macro on): wr_en at full, no rd_en -> overflow=1 and held; rd_en at empty -> underflow=1;
//    err_clr pulse -> both 0. Macro off: same stimulus -> both stay 0.
//  6 Thresholds: AF_LEVEL=3, AE_LEVEL=2, DEPTH=4, WIDTH=8 -> almost_empty for counts 0..2,
//    almost_full for 3..4.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO, first-word-fall-through read side.
// Optional sticky error flags: define SYNC_FIFO_STICKY_ERR_EN.
module sync_fifo_param #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     buffer_empty,
    output logic                     buffer_full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   fill_count,
    input  logic                     err_clr,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
    localparam logic [PW-1:0] AF_CNT   = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_CNT   = PW'(AE_LEVEL);
    localparam logic [PW-1:0] ONE      = PW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    count_q;
    logic             push;
    logic             pop;

    // A full FIFO still accepts a write when the head leaves in the same cycle
    assign pop  = rd_en & ~buffer_empty;
    assign push = wr_en & (~buffer_full | pop);

    // Pointer registers; extra MSB lets them wrap freely
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ONE;
            if (pop)  rd_ptr <= rd_ptr + ONE;
        end
    end

    // Occupancy tracks push/pop; simultaneous push and pop leave it unchanged
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count_q <= count_q + ONE;
                2'b01:   count_q <= count_q - ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are deliberately not reset
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // Head of queue is presented combinationally (zero-cycle read)
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Status flags all decode the registered count so they cannot glitch
    assign fill_count   = count_q;
    assign buffer_empty = (count_q == '0);
    assign buffer_full  = (count_q == FULL_CNT);
    assign rd_valid     = ~buffer_empty;
    assign almost_empty = (count_q <= AE_CNT);
    assign almost_full  = (count_q >= AF_CNT);

`ifdef SYNC_FIFO_STICKY_ERR_EN
    logic ovf_q;
    logic unf_q;

    // Sticky errors; a new error in the clearing cycle keeps the flag set
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (wr_en & buffer_full & ~pop) ovf_q <= 1'b1;
            else if (err_clr)               ovf_q <= 1'b0;
            if (rd_en & buffer_empty)       unf_q <= 1'b1;
            else if (err_clr)               unf_q <= 1'b0;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`else
    logic unused_err_clr;

    // Error reporting compiled out; ports stay for a uniform footprint
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: default instance plus a small-threshold one.
// Expected data comes from a scoreboard queue filled as words are driven.
module tb_sync_fifo_param;

    localparam int D = 8;
`ifdef SYNC_FIFO_STICKY_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic        err_clr = 1'b0;
    logic [15:0] wr_data = '0;
    logic [15:0] rd_data;
    logic        rd_valid, buffer_empty, buffer_full;
    logic        almost_empty, almost_full, overflow, underflow;
    logic [3:0]  fill_count;

    logic        s_wr = 1'b0;
    logic        s_rd = 1'b0;
    logic [7:0]  s_wdata = '0;
    logic [7:0]  s_rdata;
    logic        s_valid, s_empty, s_full, s_ae, s_af, s_ovf, s_unf;
    logic [2:0]  s_count;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [15:0] sb[$];
    logic [7:0]  s_sb[$];

    always #5 clock = ~clock;

    sync_fifo_param u_dut (
        .clock(clock), .reset(reset),
        .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .buffer_empty(buffer_empty),
        .buffer_full(buffer_full), .almost_empty(almost_empty),
        .almost_full(almost_full), .fill_count(fill_count),
        .err_clr(err_clr), .overflow(overflow),
        .underflow(underflow)
    );

    sync_fifo_param #(
        .WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(2)
    ) u_small (
        .clock(clock), .reset(reset),
        .wr_en(s_wr), .wr_data(s_wdata),
        .rd_en(s_rd), .rd_data(s_rdata),
        .rd_valid(s_valid), .buffer_empty(s_empty),
        .buffer_full(s_full), .almost_empty(s_ae),
        .almost_full(s_af), .fill_count(s_count),
        .err_clr(1'b0), .overflow(s_ovf),
        .underflow(s_unf)
    );

    // One clock of traffic on the default FIFO; model updated after the edge
    task automatic cycle(input logic w, input logic [15:0] d,
                         input logic r, output logic popped,
                         output logic [15:0] got,
                         output logic [15:0] exp);
        bit pop_m;
        bit push_m;
        wr_en = w;
        wr_data = d;
        rd_en = r;
        pop_m = r && (sb.size() > 0);
        push_m = w && ((sb.size() < D) || pop_m);
        popped = pop_m;
        got = rd_data;
        exp = pop_m ? sb[0] : 16'h0;
        @(posedge clock);
        #1;
        if (pop_m) void'(sb.pop_front());
        if (push_m) sb.push_back(d);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        logic p;
        logic [15:0] g, e;
        #2;
        n_checks++;
        if (fill_count !== 4'd0 || buffer_empty !== 1'b1 ||
            rd_valid !== 1'b0 || almost_empty !== 1'b1 ||
            buffer_full !== 1'b0 || almost_full !== 1'b0)
            $display("FAIL reset_init got cnt=%0d e=%b v=%b ae=%b f=%b af=%b want 0 1 0 1 0 0",
                     fill_count, buffer_empty, rd_valid,
                     almost_empty, buffer_full, almost_full);
        else n_pass++;
        n_checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0)
            $display("FAIL reset_err got %b%b want 00",
                     overflow, underflow);
        else n_pass++;
        @(posedge clock);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'h0A00 + 16'(i), 1'b0, p, g, e);
        n_checks++;
        if (fill_count !== 4'd3)
            $display("FAIL pre_reset_cnt got %0d want 3", fill_count);
        else n_pass++;
        wr_en = 1'b1;
        reset = 1'b0;
        #1;
        n_checks++;
        if (fill_count !== 4'd0 || buffer_empty !== 1'b1 ||
            rd_valid !== 1'b0)
            $display("FAIL async_reset got cnt=%0d e=%b v=%b want 0 1 0",
                     fill_count, buffer_empty, rd_valid);
        else n_pass++;
        sb.delete();
        s_sb.delete();
        wr_en = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_fill_drain();
        logic p;
        logic [15:0] g, e;
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 16'(i), 1'b0, p, g, e);
            n_checks++;
            if (fill_count !== 4'(i) || almost_full !== (i >= 6) ||
                buffer_full !== (i == 8))
                $display("FAIL fill_%0d got cnt=%0d af=%b f=%b",
                         i, fill_count, almost_full, buffer_full);
            else n_pass++;
        end
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, 16'h0, 1'b1, p, g, e);
            n_checks++;
            if (!p || g !== 16'(i) || g !== e)
                $display("FAIL drain_%0d got %h want %h", i, g, 16'(i));
            else n_pass++;
        end
        n_checks++;
        if (buffer_empty !== 1'b1 || rd_valid !== 1'b0 ||
            fill_count !== 4'd0)
            $display("FAIL drained got e=%b v=%b cnt=%0d want 1 0 0",
                     buffer_empty, rd_valid, fill_count);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic p;
        logic [15:0] g, e;
        for (int i = 0; i < 20; i++) begin
            cycle((i % 5) != 4, 16'h2000 + 16'(i), (i % 3) != 0, p, g, e);
            n_checks++;
            if (fill_count !== 4'(sb.size()) || (p && g !== e) ||
                rd_valid !== (sb.size() != 0))
                $display("FAIL wrap_%0d got cnt=%0d d=%h want cnt=%0d d=%h",
                         i, fill_count, g, sb.size(), e);
            else n_pass++;
        end
        for (int k = 0; k <= D && sb.size() > 0; k++) begin
            cycle(1'b0, 16'h0, 1'b1, p, g, e);
            n_checks++;
            if (!p || g !== e)
                $display("FAIL wrap_drain got %h want %h", g, e);
            else n_pass++;
        end
    endtask

    task automatic test_full_rw();
        logic p;
        logic [15:0] g, e;
        for (int i = 0; i < 8; i++) cycle(1'b1, 16'h0100 + 16'(i), 1'b0, p, g, e);
        cycle(1'b1, 16'hBEEF, 1'b1, p, g, e);
        n_checks++;
        if (!p || g !== 16'h0100 || fill_count !== 4'd8 ||
            buffer_full !== 1'b1 || overflow !== 1'b0)
            $display("FAIL full_rw got d=%h cnt=%0d f=%b ovf=%b want 0100 8 1 0",
                     g, fill_count, buffer_full, overflow);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 16'h0, 1'b1, p, g, e);
            n_checks++;
            if (!p || g !== e)
                $display("FAIL full_rw_drain got %h want %h", g, e);
            else n_pass++;
        end
        n_checks++;
        if (g !== 16'hBEEF)
            $display("FAIL full_rw_last got %h want beef", g);
        else n_pass++;
    endtask

    task automatic test_errors();
        logic p;
        logic [15:0] g, e;
        cycle(1'b0, 16'h0, 1'b1, p, g, e);
        n_checks++;
        if (underflow !== ERR_ON || overflow !== 1'b0)
            $display("FAIL underflow got u=%b o=%b want u=%b o=0",
                     underflow, overflow, ERR_ON);
        else n_pass++;
        for (int i = 0; i < 8; i++) cycle(1'b1, 16'h0300 + 16'(i), 1'b0, p, g, e);
        cycle(1'b1, 16'hDEAD, 1'b0, p, g, e);
        n_checks++;
        if (overflow !== ERR_ON || fill_count !== 4'd8 ||
            rd_data !== 16'h0300)
            $display("FAIL overflow got o=%b cnt=%0d head=%h want o=%b 8 0300",
                     overflow, fill_count, rd_data, ERR_ON);
        else n_pass++;
        cycle(1'b0, 16'h0, 1'b0, p, g, e);
        n_checks++;
        if (overflow !== ERR_ON || underflow !== ERR_ON)
            $display("FAIL err_hold got o=%b u=%b want %b",
                     overflow, underflow, ERR_ON);
        else n_pass++;
        err_clr = 1'b1;
        cycle(1'b0, 16'h0, 1'b0, p, g, e);
        err_clr = 1'b0;
        n_checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0)
            $display("FAIL err_clr got o=%b u=%b want 0 0",
                     overflow, underflow);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 16'h0, 1'b1, p, g, e);
            n_checks++;
            if (!p || g !== 16'h0300 + 16'(i))
                $display("FAIL ovf_drain got %h want %h",
                         g, 16'h0300 + 16'(i));
            else n_pass++;
        end
    endtask

    task automatic test_thresholds();
        n_checks++;
        if (s_count !== 3'd0 || s_ae !== 1'b1 || s_af !== 1'b0)
            $display("FAIL thr_0 got cnt=%0d ae=%b af=%b want 0 1 0",
                     s_count, s_ae, s_af);
        else n_pass++;
        for (int c = 1; c <= 4; c++) begin
            s_wr = 1'b1;
            s_wdata = 8'h40 + 8'(c);
            s_sb.push_back(s_wdata);
            @(posedge clock);
            #1;
            s_wr = 1'b0;
            n_checks++;
            if (s_count !== 3'(c) || s_ae !== (c <= 2) ||
                s_af !== (c >= 3) || s_full !== (c == 4))
                $display("FAIL thr_up_%0d got cnt=%0d ae=%b af=%b f=%b",
                         c, s_count, s_ae, s_af, s_full);
            else n_pass++;
        end
        for (int c = 3; c >= 0; c--) begin
            n_checks++;
            if (s_rdata !== s_sb[0])
                $display("FAIL thr_data got %h want %h", s_rdata, s_sb[0]);
            else n_pass++;
            void'(s_sb.pop_front());
            s_rd = 1'b1;
            @(posedge clock);
            #1;
            s_rd = 1'b0;
            n_checks++;
            if (s_count !== 3'(c) || s_ae !== (c <= 2) ||
                s_af !== (c >= 3) || s_empty !== (c == 0))
                $display("FAIL thr_dn_%0d got cnt=%0d ae=%b af=%b e=%b",
                         c, s_count, s_ae, s_af, s_empty);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_full_rw();
        test_errors();
        test_thresholds();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
